// File: rtl/reservation_station_adder.sv
// Single-entry reservation station in front of an adder/subtractor functional unit.
// It accepts one ADD/SUB/ADDI/SUBI at a time, waits for missing operands by snooping
// the result bus, executes for LATENCY cycles, then broadcasts one cycle into its tag slot.
module reservation_station_adder #(
  parameter int unsigned         WORD_SIZE = 32,
  parameter int unsigned         RB_SIZE   = 16,
  parameter int unsigned         RB_INDEX  = 5,
  parameter int unsigned         REG_INDEX = 5,
  parameter int unsigned         FU_INDEX  = 4,
  parameter logic [FU_INDEX-1:0] FU_ID     = '0,
  parameter logic [FU_INDEX-1:0] NO_FU     = 4'b1111,
  parameter logic [RB_INDEX-1:0] READY     = 5'b11111,
  parameter int unsigned         LATENCY   = 2,
  parameter logic [5:0]          INST_ADD  = 6'h01,
  parameter logic [5:0]          INST_SUB  = 6'h02,
  parameter logic [5:0]          INST_ADDI = 6'h03,
  parameter logic [5:0]          INST_SUBI = 6'h04
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FU_INDEX-1:0]           CDB_inst_fu,
  input  logic [WORD_SIZE-1:0]          CDB_inst_inst,
  input  logic [RB_INDEX-1:0]           CDB_inst_RBindex,
  output logic [REG_INDEX-1:0]          numj,
  output logic [REG_INDEX-1:0]          numk,
  input  logic [WORD_SIZE-1:0]          vj,
  input  logic [WORD_SIZE-1:0]          vk,
  input  logic [RB_INDEX-1:0]           qj,
  input  logic [RB_INDEX-1:0]           qk,
  input  logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_data_in,
  input  logic [RB_SIZE-1:0]            CDB_data_valid_in,
  output logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_addr,
  output logic                          busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IMM_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                   r_state;
  logic [1:0]                   w_next_state;
  logic [WORD_SIZE-1:0]         r_a;
  logic [WORD_SIZE-1:0]         r_b;
  logic [RB_INDEX-1:0]          r_qj;
  logic [RB_INDEX-1:0]          r_qk;
  logic                         r_pj;
  logic                         r_pk;
  logic                         r_sub;
  logic [RB_INDEX-1:0]          r_tag;
  logic [CNT_W-1:0]             r_cnt;
  logic [RB_SIZE-1:0]           r_cdb_valid;
  logic [RB_SIZE*WORD_SIZE-1:0] r_cdb_data;

  logic [5:0]                   w_opcode;
  logic [REG_INDEX-1:0]         w_rs;
  logic [REG_INDEX-1:0]         w_rt;
  logic [WORD_SIZE-1:0]         w_imm_sext;
  logic                         w_is_imm;
  logic                         w_is_sub;
  logic                         w_opc_ok;
  logic                         w_lookup;
  logic                         w_accept;
  logic                         w_j_rdy;
  logic                         w_k_rdy;
  logic [WORD_SIZE-1:0]         w_j_val;
  logic [WORD_SIZE-1:0]         w_k_val;
  logic                         w_j_res;
  logic                         w_k_res;
  logic [WORD_SIZE-1:0]         w_j_snoop;
  logic [WORD_SIZE-1:0]         w_k_snoop;
  logic [WORD_SIZE-1:0]         w_result;
  logic                         w_unused_rd;

  // Valid bit of a snooped result-bus slot; tags beyond the bus never match.
  function automatic logic slot_valid(input logic [RB_INDEX-1:0] q,
                                      input logic [RB_SIZE-1:0]  vin);
    slot_valid = 1'b0;
    for (int unsigned i = 0; i < RB_SIZE; i++) begin
      if (q == RB_INDEX'(i)) slot_valid = vin[i];
    end
  endfunction

  // Data word of a snooped result-bus slot.
  function automatic logic [WORD_SIZE-1:0] slot_data(input logic [RB_INDEX-1:0]          q,
                                                     input logic [RB_SIZE*WORD_SIZE-1:0] din);
    slot_data = '0;
    for (int unsigned i = 0; i < RB_SIZE; i++) begin
      if (q == RB_INDEX'(i)) slot_data = din[i*WORD_SIZE +: WORD_SIZE];
    end
  endfunction

  // Instruction field decode.
  assign w_opcode    = CDB_inst_inst[31:26];
  assign w_rs        = REG_INDEX'(CDB_inst_inst[20:16]);
  assign w_rt        = REG_INDEX'(CDB_inst_inst[15:11]);
  assign w_imm_sext  = {{(WORD_SIZE-IMM_W){CDB_inst_inst[15]}}, CDB_inst_inst[IMM_W-1:0]};
  assign w_unused_rd = ^CDB_inst_inst[25:21];
  assign w_is_imm    = (w_opcode == INST_ADDI) || (w_opcode == INST_SUBI);
  assign w_is_sub    = (w_opcode == INST_SUB)  || (w_opcode == INST_SUBI);
  assign w_opc_ok    = (w_opcode == INST_ADD)  || (w_opcode == INST_SUB) || w_is_imm;

  // Register-file lookup indices are only driven while this idle unit is being addressed.
  assign w_lookup = (r_state == S_IDLE) && (CDB_inst_fu == FU_ID);
  assign numj     = w_lookup ? w_rs : 'z;
  assign numk     = w_lookup ? w_rt : 'z;

  assign w_accept = w_lookup && (CDB_inst_fu != NO_FU) && w_opc_ok &&
                    (CDB_inst_RBindex != READY);

  // Operand capture at issue: register file, then same-cycle bus forward, else pending.
  always_comb begin
    w_j_rdy = 1'b0;
    w_j_val = '0;
    w_k_rdy = 1'b0;
    w_k_val = '0;
    if (qj == READY) begin
      w_j_rdy = 1'b1;
      w_j_val = vj;
    end else if (slot_valid(qj, CDB_data_valid_in)) begin
      w_j_rdy = 1'b1;
      w_j_val = slot_data(qj, CDB_data_data_in);
    end
    if (w_is_imm) begin
      w_k_rdy = 1'b1;
      w_k_val = w_imm_sext;
    end else if (qk == READY) begin
      w_k_rdy = 1'b1;
      w_k_val = vk;
    end else if (slot_valid(qk, CDB_data_valid_in)) begin
      w_k_rdy = 1'b1;
      w_k_val = slot_data(qk, CDB_data_data_in);
    end
  end

  // Pending-operand resolution while waiting.
  assign w_j_res   = r_pj && slot_valid(r_qj, CDB_data_valid_in);
  assign w_k_res   = r_pk && slot_valid(r_qk, CDB_data_valid_in);
  assign w_j_snoop = slot_data(r_qj, CDB_data_data_in);
  assign w_k_snoop = slot_data(r_qk, CDB_data_data_in);

  assign w_result  = r_sub ? (r_a - r_b) : (r_a + r_b);

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = (w_j_rdy && w_k_rdy) ? S_EXEC : S_WAIT;
      S_WAIT: if ((!r_pj || w_j_res) && (!r_pk || w_k_res)) w_next_state = S_EXEC;
      S_EXEC: if (r_cnt == '0) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Operand capture, execute countdown and the one-cycle result broadcast.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_qj        <= '0;
      r_qk        <= '0;
      r_pj        <= 1'b0;
      r_pk        <= 1'b0;
      r_sub       <= 1'b0;
      r_tag       <= '0;
      r_cnt       <= '0;
      r_cdb_valid <= '0;
      r_cdb_data  <= '0;
    end else begin
      r_cdb_valid <= '0;
      r_cdb_data  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tag <= CDB_inst_RBindex;
            r_sub <= w_is_sub;
            r_a   <= w_j_val;
            r_b   <= w_k_val;
            r_pj  <= !w_j_rdy;
            r_pk  <= !w_k_rdy;
            r_qj  <= qj;
            r_qk  <= w_is_imm ? READY : qk;
            r_cnt <= CNT_W'(LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (w_j_res) begin
            r_a  <= w_j_snoop;
            r_pj <= 1'b0;
          end
          if (w_k_res) begin
            r_b  <= w_k_snoop;
            r_pk <= 1'b0;
          end
          r_cnt <= CNT_W'(LATENCY - 1);
        end
        S_EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            for (int unsigned i = 0; i < RB_SIZE; i++) begin
              if (r_tag == RB_INDEX'(i)) begin
                r_cdb_valid[i]                      <= 1'b1;
                r_cdb_data[i*WORD_SIZE +: WORD_SIZE] <= w_result;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign CDB_data_valid = r_cdb_valid;
  assign CDB_data_data  = r_cdb_data;
  assign CDB_data_addr  = '0;

endmodule

// File: tb/tb_reservation_station_adder.sv
// Bench for reservation_station_adder: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against an event-timed model.
module tb_reservation_station_adder;

  localparam int unsigned W    = 32;
  localparam int unsigned RBS  = 16;
  localparam int unsigned DW   = RBS * W;
  localparam int unsigned LAT  = 2;
  localparam logic [3:0]  FUID = 4'd0;
  localparam logic [3:0]  NOFU = 4'hF;
  localparam logic [4:0]  RDY  = 5'h1F;
  localparam logic [5:0]  OP_ADD  = 6'h01;
  localparam logic [5:0]  OP_SUB  = 6'h02;
  localparam logic [5:0]  OP_ADDI = 6'h03;
  localparam logic [5:0]  OP_SUBI = 6'h04;
  localparam int          NEVER   = 1000000000;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    fu;
  logic [W-1:0]  inst;
  logic [4:0]    rbidx;
  logic [W-1:0]  vj, vk;
  logic [4:0]    qj, qk;
  logic [DW-1:0] din;
  logic [RBS-1:0] vin;
  wire  [4:0]    numj, numk;
  wire  [DW-1:0] dout, daddr;
  wire  [RBS-1:0] vout;
  wire           busy;

  int n_vec = 0;
  int n_bad = 0;

  reservation_station_adder #(
    .LATENCY(LAT), .FU_ID(FUID), .NO_FU(NOFU), .READY(RDY),
    .INST_ADD(OP_ADD), .INST_SUB(OP_SUB), .INST_ADDI(OP_ADDI), .INST_SUBI(OP_SUBI)
  ) dut (
    .clk(clk), .reset(reset),
    .CDB_inst_fu(fu), .CDB_inst_inst(inst), .CDB_inst_RBindex(rbidx),
    .numj(numj), .numk(numk),
    .vj(vj), .vk(vk), .qj(qj), .qk(qk),
    .CDB_data_data_in(din), .CDB_data_valid_in(vin),
    .CDB_data_data(dout), .CDB_data_valid(vout), .CDB_data_addr(daddr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Model: one instruction in flight, described by when its result must appear.
  int          m_cyc    = 0;
  bit          m_init   = 0;
  bit          m_active = 0;
  bit          m_pj, m_pk, m_sub;
  int          m_qj, m_qk, m_tag;
  logic [W-1:0] m_a, m_b;
  int          m_bcast = NEVER;

  always @(posedge clk) begin
    logic [5:0] op;
    int         q;
    m_cyc++;
    op = inst[31:26];
    if (!reset) begin
      m_active = 0;
      m_init   = 1;
    end else if (m_active) begin
      if (m_cyc == m_bcast + 1) begin
        m_active = 0;
      end else if (m_pj || m_pk) begin
        if (m_pj && vin[m_qj]) begin m_a = din[m_qj*W +: W]; m_pj = 0; end
        if (m_pk && vin[m_qk]) begin m_b = din[m_qk*W +: W]; m_pk = 0; end
        if (!m_pj && !m_pk) m_bcast = m_cyc + LAT;
      end
    end else if (fu == FUID && rbidx != RDY &&
                 (op == OP_ADD || op == OP_SUB || op == OP_ADDI || op == OP_SUBI)) begin
      m_active = 1;
      m_tag    = int'(rbidx);
      m_sub    = (op == OP_SUB || op == OP_SUBI);
      q = int'(qj);
      m_pj = 0;
      if (qj == RDY)    m_a = vj;
      else if (vin[q])  m_a = din[q*W +: W];
      else begin m_pj = 1; m_qj = q; end
      q = int'(qk);
      m_pk = 0;
      if (op == OP_ADDI || op == OP_SUBI) m_b = {{16{inst[15]}}, inst[15:0]};
      else if (qk == RDY) m_b = vk;
      else if (vin[q])    m_b = din[q*W +: W];
      else begin m_pk = 1; m_qk = q; end
      m_bcast = (!m_pj && !m_pk) ? m_cyc + LAT : NEVER;
    end
  end

  // Every-cycle comparison of all broadcast outputs against the model.
  always @(negedge clk) begin
    logic [RBS-1:0] e_valid;
    logic [DW-1:0]  e_data;
    if (m_init) begin
      e_valid = '0;
      e_data  = '0;
      if (m_active && m_cyc == m_bcast) begin
        e_valid[m_tag]      = 1'b1;
        e_data[m_tag*W +: W] = m_sub ? (m_a - m_b) : (m_a + m_b);
      end
      chk("busy",  DW'(busy),  DW'(m_active));
      chk("valid", DW'(vout),  DW'(e_valid));
      chk("data",  dout,       e_data);
      chk("addr",  daddr,      '0);
    end
  end

  task automatic set_idle();
    fu = NOFU; inst = '0; rbidx = '0; qj = RDY; qk = RDY;
    vj = '0; vk = '0; vin = '0; din = '0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [15:0] low,
                       input logic [4:0] tag, input logic [4:0] j, input logic [4:0] k,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    fu = FUID; inst = {op, 5'd0, rs, low}; rbidx = tag;
    qj = j; qk = k; vj = a; vk = b;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] tmp;
    logic [5:0]    ops [4];
    logic [5:0]    op;
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_ADDI; ops[3] = OP_SUBI;

    reset = 1'b0;
    set_idle();
    tick(); tick();
    chk("reset_busy",  DW'(busy), '0);
    chk("reset_valid", DW'(vout), '0);
    reset = 1'b1;
    tick();

    // ADD 5+7 into tag 3, both operands from the register file
    issue(OP_ADD, 5'd1, {5'd2, 11'd0}, 5'd3, RDY, RDY, 32'd5, 32'd7);
    #1;
    chk("numj", DW'(numj), DW'(5'd1));
    chk("numk", DW'(numk), DW'(5'd2));
    tick();
    chk("add_busy_e0", DW'(busy), DW'(1'b1));
    set_idle();
    tick();
    chk("add_valid_e1", DW'(vout), '0);
    tick();
    chk("add_valid_e2", DW'(vout), DW'(16'h0008));
    tmp = dout;
    chk("add_slot3", DW'(tmp[3*W +: W]), DW'(32'd12));
    tick();
    chk("add_idle_e3", DW'(busy), '0);

    // SUBI with rs pending on tag 6, imm -1; qk looks pending but must be ignored
    issue(OP_SUBI, 5'd4, 16'hFFFF, 5'd5, 5'd6, 5'd7, 32'd0, 32'd0);
    tick();
    chk("subi_busy", DW'(busy), DW'(1'b1));
    set_idle();
    tick();
    chk("subi_wait", DW'(vout), '0);
    vin[6] = 1'b1;
    din[6*W +: W] = 32'd10;
    tick();
    set_idle();
    tick();
    chk("subi_exec", DW'(vout), '0);
    tick();
    chk("subi_valid", DW'(vout), DW'(16'h0020));
    tmp = dout;
    chk("subi_slot5", DW'(tmp[5*W +: W]), DW'(32'd11));
    tick();

    // Wraparound: FFFFFFFF + 1 = 0 into tag 0
    issue(OP_ADD, 5'd1, 16'd0, 5'd0, RDY, RDY, 32'hFFFF_FFFF, 32'd1);
    tick(); set_idle(); tick(); tick();
    chk("wrap_valid", DW'(vout), DW'(16'h0001));
    chk("wrap_data",  dout, '0);
    tick();

    // Issue during DONE is refused, as are bad opcode, READY tag and foreign FU
    issue(OP_ADD, 5'd1, 16'd0, 5'd2, RDY, RDY, 32'd1, 32'd2);
    tick(); set_idle(); tick(); tick();
    chk("done_valid", DW'(vout), DW'(16'h0004));
    issue(OP_ADD, 5'd1, 16'd0, 5'd9, RDY, RDY, 32'd3, 32'd4);
    tick();
    chk("done_refused", DW'(busy), '0);
    issue(6'h3F, 5'd1, 16'd0, 5'd4, RDY, RDY, 32'd3, 32'd4);
    tick();
    chk("badop_refused", DW'(busy), '0);
    issue(OP_ADD, 5'd1, 16'd0, RDY, RDY, RDY, 32'd3, 32'd4);
    tick();
    chk("readytag_refused", DW'(busy), '0);
    issue(OP_ADD, 5'd1, 16'd0, 5'd4, RDY, RDY, 32'd3, 32'd4);
    fu = 4'd3;
    tick();
    chk("otherfu_refused", DW'(busy), '0);
    set_idle();
    tick();

    // Reset during EXEC discards the instruction
    issue(OP_ADD, 5'd1, 16'd0, 5'd7, RDY, RDY, 32'd8, 32'd9);
    tick();
    chk("rst_exec_busy", DW'(busy), DW'(1'b1));
    set_idle();
    reset = 1'b0;
    tick();
    chk("rst_busy", DW'(busy), '0);
    reset = 1'b1;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      tick();
      chk("rst_no_bcast", DW'(vout), '0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      fu    = ($urandom_range(0, 9) < 6) ? FUID : 4'($urandom_range(1, 15));
      op    = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 3)] : 6'($urandom);
      inst  = {op, 26'($urandom)};
      rbidx = ($urandom_range(0, 19) == 0) ? RDY : 5'($urandom_range(0, 15));
      qj    = ($urandom_range(0, 1) != 0) ? RDY : 5'($urandom_range(0, 15));
      qk    = ($urandom_range(0, 1) != 0) ? RDY : 5'($urandom_range(0, 15));
      vj    = $urandom;
      vk    = $urandom;
      for (int i = 0; i < int'(RBS); i++) begin
        vin[i]       = ($urandom_range(0, 5) == 0);
        din[i*W +: W] = $urandom;
      end
      #1;
      if (!m_active && m_init && fu == FUID) begin
        chk("numj_rand", DW'(numj), DW'(inst[20:16]));
        chk("numk_rand", DW'(numk), DW'(inst[15:11]));
      end
      tick();
    end

    set_idle();
    reset = 1'b1;
    repeat (LAT + 3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reservation_station_adder.md
RESERVATION_STATION_ADDER -- requirements
Module: reservation_station_adder

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- WORD_SIZE, 32, datapath width
- RB_SIZE, 16, reorder-buffer entries
- RB_INDEX, 5, tag width
- REG_INDEX, 5, register index width
- FU_INDEX, 4, FU id width
- FU_ID, 0, this unit's id
- NO_FU, 4'b1111, no-issue code
- READY, 5'b11111, "value present" tag
- LATENCY, 2, execute cycles, legal range 1..15
- INST_ADD, INST_SUB, INST_ADDI, INST_SUBI, codebase values, accepted opcodes
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, synchronous active-low reset
- CDB_inst_fu, in, FU_INDEX, target FU of issue
- CDB_inst_inst, in, WORD_SIZE, issued instruction
- CDB_inst_RBindex, in, RB_INDEX, destination tag
- numj, out, REG_INDEX, rs lookup index
- numk, out, REG_INDEX, rt lookup index
- vj, in, WORD_SIZE, rs value from register file
- vk, in, WORD_SIZE, rt value from register file
- qj, in, RB_INDEX, rs producer tag
- qk, in, RB_INDEX, rt producer tag
- CDB_data_data_in, in, RB_SIZE*WORD_SIZE, snooped result bus
- CDB_data_valid_in, in, RB_SIZE, snooped valid bits
- CDB_data_data, out, RB_SIZE*WORD_SIZE, result in slot tag, zero elsewhere
- CDB_data_valid, out, RB_SIZE, one-hot result valid
- CDB_data_addr, out, RB_SIZE*WORD_SIZE, always zero
- busy, out, 1, unit occupied
REQ-004 Instruction fields SHALL be: opcode [31:26], rd [25:21], rs [20:16], rt [15:11], imm [15:0] (sign-extended).

Function
REQ-005 SHALL have states IDLE, WAIT_OPS, EXEC, DONE; busy SHALL be 1 in every state except IDLE, decoded from the state register.
REQ-006 Issue SHALL be accepted at a posedge only when state==IDLE, CDB_inst_fu==FU_ID, and the opcode is one of the four accepted opcodes; any other opcode SHALL be ignored, leaving the unit IDLE.
REQ-007 While IDLE and CDB_inst_fu==FU_ID, numj/numk SHALL combinationally drive rs/rt; otherwise numj/numk SHALL be high-impedance.
REQ-008 At acceptance, an operand is captured when:
- its q==READY: capture v;
- else CDB_data_valid_in[q]==1: capture that slot's data;
- else store tag q and mark the operand pending.
REQ-009 ADDI/SUBI second operand SHALL be sign-extended imm, always ready; qk is ignored.
REQ-010 In WAIT_OPS, each posedge SHALL capture every pending operand whose tag's CDB_data_valid_in bit is 1; both operands may resolve on the same edge.
REQ-011 State transitions:
- IDLE→EXEC at acceptance if both operands are ready, else IDLE→WAIT_OPS.
- WAIT_OPS→EXEC at the edge the last operand is captured.
- EXEC lasts exactly LATENCY cycles (counter loaded with LATENCY-1, decremented to 0), then →DONE.
- DONE lasts exactly one cycle, then →IDLE.
REQ-012 Result SHALL be ADD/ADDI rs+op2 and SUB/SUBI rs-op2, modulo 2^WORD_SIZE; overflow is ignored.
REQ-013 In DONE, CDB_data_valid[tag] SHALL be 1, CDB_data_data slot tag SHALL hold the result, and all other bits SHALL be 0; outside DONE all CDB outputs SHALL be 0.
REQ-014 A new issue presented in the DONE cycle SHALL be refused (busy=1); the earliest acceptance is the edge after DONE.
REQ-015 Tag equal to READY at issue SHALL be ignored (unit stays IDLE).

Reset
REQ-016 When reset==0 at a posedge:
- state→IDLE, busy=0;
- CDB_data_valid, CDB_data_data, CDB_data_addr = 0;
- counter, captured operands and tags cleared.
REQ-017 Reset mid-operation (WAIT_OPS/EXEC/DONE) SHALL discard the instruction with no broadcast in any later cycle.

Verification
REQ-018 ADD, qj=qk=READY, vj=5, vk=7, tag 3, issue edge E0 → busy from E0, CDB_data_valid=16'h0008 and slot3=12 only during cycle after E0+2, IDLE after E0+3.
REQ-019 SUBI rs with qj=6 pending, imm=16'hFFFF, CDB_data_valid_in[6]=1 with data 10 at edge E1 → EXEC from E1, result 11 broadcast in tag slot after E1+LATENCY.
REQ-020 ADD 32'hFFFFFFFF+1 → result 0, no other flag or slot set.
REQ-021 Issue to FU_ID while DONE, and issue of a non-adder opcode while IDLE → neither accepted; no busy, no broadcast.
REQ-022 reset=0 during EXEC → next cycle busy=0, CDB_data_valid stays 0 through LATENCY+2 cycles.
